// File: rtl/gpio_sw_debounce.sv
// Switch synchroniser, per-bit debouncer and sticky change flags packed for gpio_bi.
// Build option: define SW_DEBOUNCE_IRQ_EN to register irq_o from the change flags.
module gpio_sw_debounce #(
  parameter int NBITS           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [NBITS-1:0] sw_i,
  input  logic [NBITS-1:0] clr_i,
  output logic [NBITS-1:0] sw_db_o,
  output logic [NBITS-1:0] chg_o,
  output logic [31:0]      gpio_o,
  output logic             irq_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] THR = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] sync_q [SYNC_STAGES];
  logic [NBITS-1:0] sync;
  logic [CW-1:0]    cnt_q  [NBITS];
  logic [CW-1:0]    cnt_d  [NBITS];
  logic [NBITS-1:0] db_q, db_d;
  logic [NBITS-1:0] chg_q, chg_d;
  logic [NBITS-1:0] set;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sw_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Any cycle back at the accepted level restarts the count.
  always_comb begin
    db_d = db_q;
    set  = '0;
    for (int i = 0; i < NBITS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == THR) begin
        db_d[i]  = sync[i];
        cnt_d[i] = '0;
        set[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    chg_d = (chg_q & ~clr_i) | set;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NBITS; i++) cnt_q[i] <= '0;
      db_q  <= '0;
      chg_q <= '0;
    end else begin
      for (int i = 0; i < NBITS; i++) cnt_q[i] <= cnt_d[i];
      db_q  <= db_d;
      chg_q <= chg_d;
    end
  end

  assign sw_db_o = db_q;
  assign chg_o   = chg_q;

  generate
    if (NBITS == 16) begin : g_pack16
      assign gpio_o = {8'h0, db_q, 8'h0};
    end else begin : g_packn
      assign gpio_o = 32'(db_q) << 8;
    end
  endgenerate

`ifdef SW_DEBOUNCE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) irq_q <= 1'b0;
    else        irq_q <= |chg_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
